// File: rtl/bin2bcd_seq_pkg.sv
// bcd_pkg: shared types and constant helpers for the bin2bcd_seq converter.
// Digit sizing and significant-digit count live here.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    localparam int MAXD = 16;

    // Smallest d with 10^d >= 2^width.
    function automatic int min_digits(input int width);
        longint p;
        int d;
        p = 1;
        d = 0;
        for (int i = 0; i < MAXD; i++) begin
            if (p < (longint'(1) << width)) begin
                p = (p << 3) + (p << 1);
                d = d + 1;
            end
        end
        return d;
    endfunction

    function automatic int sig_digits(
        input logic [4*MAXD-1:0] bcd,
        input int n
    );
        int r;
        r = 1;
        for (int i = 0; i < MAXD; i++) begin
            if (i < n && bcd[4*i +: 4] != 4'd0)
                r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready bus for bin2bcd_seq: binary request in, packed BCD out.
// master = producer/consumer side, slave = converter side.
interface bin2bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    localparam int NDW = $clog2(DIGITS + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [NDW-1:0]        out_ndig;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bcd,
        input  out_ndig
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bcd,
        output out_ndig
    );
endinterface

// File: rtl/bin2bcd_seq_adj3.sv
// bcd_adj3: double-dabble digit correction, +3 when the digit is 5 or more.
// Purely combinational; the carry out of bit 3 is intentionally dropped.
module bcd_adj3 (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary to BCD converter.
// One input bit per SHIFT cycle; result held in DONE until taken.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic        clk,
    input  logic        rst,
    bin2bcd_seq_if.slave bus
);
    localparam int BW  = 4 * DIGITS;
    localparam int NDW = $clog2(DIGITS + 1);
    localparam int CW  = $clog2(WIDTH);

    generate
        if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "bin2bcd_seq: WIDTH out of range 4..32");
        end
        if (DIGITS < min_digits(WIDTH) || DIGITS > MAXD) begin : g_bad_digits
            $fatal(1, "bin2bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    bcd_state_t       st;
    bcd_state_t       nxt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_n;
    logic [BW-1:0]    bcd;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    bcd_n;
    logic [CW-1:0]    cnt;
    logic [NDW-1:0]   ndig;
    logic [NDW-1:0]   ndig_n;
    logic             rdy;
    logic             vld;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_adj3 u_adj (
                .d(bcd[4*g +: 4]),
                .q(adj[4*g +: 4])
            );
        end
    endgenerate

    // Shift shift-register MSB into the corrected BCD word.
    assign bcd_n  = {adj[BW-2:0], sh[WIDTH-1]};
    assign sh_n   = {sh[WIDTH-2:0], 1'b0};
    assign ndig_n = NDW'(sig_digits((4*MAXD)'(bcd_n), DIGITS));

    always_ff @(posedge clk) begin
        if (rst)
            st <= IDLE;
        else
            st <= nxt;
    end

    always_comb begin
        nxt = st;
        unique case (st)
            IDLE:    if (bus.in_valid) nxt = SHIFT;
            SHIFT:   if (cnt == '0) nxt = DONE;
            DONE:    if (bus.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy = 1'b0;
        vld = 1'b0;
        unique case (st)
            IDLE:    rdy = 1'b1;
            DONE:    vld = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            ndig <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh  <= bus.in_data;
                        bcd <= '0;
                        cnt <= CW'(WIDTH - 1);
                    end
                end
                SHIFT: begin
                    sh  <= sh_n;
                    bcd <= bcd_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        ndig <= ndig_n;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_bcd   = bcd;
    assign bus.out_ndig  = ndig;

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: binary input width, legal range 4..32.
REQ-002 SHALL have parameter DIGITS, default 3: BCD output digits; SHALL be at least ceil(WIDTH*log10(2)); an elaboration-time assertion SHALL reject smaller values.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts in_data.
REQ-007 SHALL have port in_data, input, WIDTH: unsigned binary value.
REQ-008 SHALL have port out_valid, output, 1: result is valid.
REQ-009 SHALL have port out_ready, output consumer ready (input, 1).
REQ-010 SHALL have port out_bcd, output, 4*DIGITS: packed BCD; digit 0 in bits [3:0] (least significant).
REQ-011 SHALL have port out_ndig, output, $clog2(DIGITS+1): number of significant digits.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-014 IDLE: on in_valid=1, SHALL capture in_data into a WIDTH-bit shift register, clear the BCD register, load bit counter = WIDTH-1, and go to SHIFT.
REQ-015 SHIFT, each cycle: every digit >= 5 SHALL first get +3 (4-bit, no carry out); then {BCD, shift} SHALL shift left one bit, with the shift-register MSB entering BCD bit 0.
REQ-016 SHIFT SHALL last exactly WIDTH cycles; after the cycle with counter = 0 the FSM SHALL go to DONE.
REQ-017 Latency: out_valid SHALL assert exactly WIDTH+1 cycles after the accepting edge.
REQ-018 DONE: out_bcd and out_ndig SHALL stay stable while out_ready = 0; on out_ready = 1 the FSM SHALL go to IDLE.
REQ-019 Throughput SHALL be one conversion per WIDTH+2 cycles with out_ready held high.
REQ-020 out_ndig SHALL equal the index of the most-significant nonzero digit plus 1, and 1 when the value is 0.
REQ-021 out_ndig SHALL be registered with out_bcd on entry to DONE, not derived combinationally from state.
REQ-022 in_data SHALL be ignored outside IDLE, and in_valid held high during SHIFT/DONE SHALL NOT start a new conversion.
REQ-023 Unused upper digits (DIGITS above the minimum) SHALL read 0.

Reset
REQ-024 With rst = 1 at a clock edge, the FSM SHALL go to IDLE, clear the BCD and shift registers, out_bcd = 0, out_ndig = 0, out_valid = 0 and in_ready = 1 on the following cycle.
REQ-025 Reset during SHIFT or DONE SHALL abandon the conversion with no output pulse; rst SHALL take priority over every handshake.

Structure
REQ-026 Package bcd_pkg SHALL hold the state enum type bcd_state_t.
REQ-027 bcd_pkg SHALL hold a constant function min_digits(width), used for the REQ-002 check.
REQ-028 bcd_pkg SHALL hold a function for the significant-digit count.
REQ-029 The design SHALL contain one combinational sub-module, bcd_adj3 (4-bit in, 4-bit out, +3 if >= 5), instantiated DIGITS times via generate.
REQ-030 The datapath SHALL use no multipliers or dividers.

Verification
REQ-031 WIDTH=8: in_data=255 accepted at cycle 0 -> out_valid at cycle 9, out_bcd=12'h255, out_ndig=3.
REQ-032 WIDTH=8: in_data=0 -> out_bcd=12'h000, out_ndig=1; in_data=9 -> 12'h009, ndig 1; in_data=10 -> 12'h010, ndig 2.
REQ-033 WIDTH=16, DIGITS=5: in_data=65535 -> out_bcd=20'h65535, ndig 5, latency 17; DIGITS=6 -> 24'h065535, ndig 5.
REQ-034 Backpressure: out_ready=0 for 10 cycles in DONE -> outputs constant, in_ready=0; a new in_valid is not accepted until one cycle after out_ready=1.
REQ-035 rst=1 in SHIFT cycle 4 -> next cycle IDLE, out_valid=0, in_ready=1; a following in_data=123 converts to 12'h123 normally.
REQ-036 Exhaustive WIDTH=8 sweep 0..255, back-to-back with out_ready=1 -> every result matches a reference decimal model, period 10 cycles.
